// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared 64-bit combinational ALU.
// One operation in flight: accept in IDLE, evaluate in EXEC, hold the result in RESP until consumed.

module alu64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [3:0]  ctrl,
    output logic [63:0] y
);
    always_comb begin
        y = '0;
        case (ctrl)
            4'b0000: y = a & b;
            4'b0001: y = a | b;
            4'b0010: y = a + b;
            4'b0110: y = a - b;
            4'b0111: y = b;
            default: y = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int N           = 64,    // the ALU below is fixed at 64 bits
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [3:0]   req0_ctrl,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [3:0]   req1_ctrl,
    output logic         resp0_valid,
    input  logic         resp0_ready,
    output logic         resp1_valid,
    input  logic         resp1_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [3:0]   ctrl;
    } op_t;

    state_t       state, state_nx;
    op_t          op_q, op_sel;
    logic         gnt, gnt_q, prio;
    logic         accept, resp_fire;
    logic [N-1:0] alu_y;

    // Both valid: prio decides; otherwise whichever one is valid.
    always_comb begin
        gnt    = (req0_valid && req1_valid) ? prio : req1_valid;
        op_sel = gnt ? op_t'{req1_a, req1_b, req1_ctrl} : op_t'{req0_a, req0_b, req0_ctrl};
    end

    assign accept     = (state == IDLE) && !reset && (req0_valid || req1_valid);
    assign req0_ready = accept && !gnt;
    assign req1_ready = accept && gnt;

    // Only the granted requester's resp_ready can complete the transaction.
    assign resp_fire   = (state == RESP) && (gnt_q ? resp1_ready : resp0_ready);
    assign resp0_valid = (state == RESP) && !gnt_q;
    assign resp1_valid = (state == RESP) && gnt_q;
    assign busy        = (state != IDLE);

    alu64 u_alu (
        .a    (op_q.a),
        .b    (op_q.b),
        .ctrl (op_q.ctrl),
        .y    (alu_y)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (resp_fire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            prio   <= 1'b0;
            op_q   <= '0;
            gnt_q  <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q  <= op_sel;
                gnt_q <= gnt;
            end
            if (state == EXEC) begin
                result <= alu_y;
                zero   <= (alu_y == '0);
            end
            if (resp_fire && ROUND_ROBIN)
                prio <= ~gnt_q;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed + randomized bench for alu_arbiter against a transaction-level reference model.

module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [63:0] result;
    logic        zero, busy;

    int n_cmp = 0;
    int n_err = 0;
    int turn  = 0;  // model: whose turn it is when both requesters are valid

    always #5 clk = ~clk;

    alu_arbiter #(.N(64), .ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    function automatic logic [63:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] c);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One full transaction, called in an IDLE cycle at posedge+1; returns at posedge+1 in IDLE.
    task automatic issue(input logic v0, input logic v1,
                         input logic [63:0] a0, input logic [63:0] b0, input logic [3:0] c0,
                         input logic [63:0] a1, input logic [63:0] b1, input logic [3:0] c1,
                         input int hold);
        int g;
        logic [63:0] exp_r;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        #1;
        g     = (v0 && v1) ? turn : (v1 ? 1 : 0);
        exp_r = (g == 1) ? ref_alu(a1, b1, c1) : ref_alu(a0, b0, c0);
        chk1("accept_ready0", req0_ready, g == 0);
        chk1("accept_ready1", req1_ready, g == 1);
        chk1("accept_busy", busy, 1'b0);
        @(posedge clk); #1;
        // Granted requester drops valid; operands change to prove they were latched.
        if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        req0_a = rnd64(); req0_b = rnd64(); req0_ctrl = 4'($urandom_range(0, 15));
        req1_a = rnd64(); req1_b = rnd64(); req1_ctrl = 4'($urandom_range(0, 15));
        #1;
        chk1("exec_busy", busy, 1'b1);
        chk1("exec_resp_valid", resp0_valid | resp1_valid, 1'b0);
        chk1("exec_ready", req0_ready | req1_ready, 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k <= hold; k++) begin
            // The non-granted resp_ready is held high to show it is ignored.
            if (g == 0) begin resp0_ready = (k == hold); resp1_ready = 1'b1; end
            else        begin resp1_ready = (k == hold); resp0_ready = 1'b1; end
            #1;
            chk1("resp_valid0", resp0_valid, g == 0);
            chk1("resp_valid1", resp1_valid, g == 1);
            chk64("resp_result", result, exp_r);
            chk1("resp_zero", zero, exp_r == 64'd0);
            chk1("resp_ready_blocked", req0_ready | req1_ready, 1'b0);
            @(posedge clk); #1;
        end
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        turn = 1 - g;
        #1;
        chk1("done_busy", busy, 1'b0);
        chk1("done_resp_valid", resp0_valid | resp1_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;

        // Reset held two cycles with req0 valid: nothing accepted.
        #1;
        chk1("rst_ready0_t0", req0_ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk1("rst_ready0", req0_ready, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_resp_valid", resp0_valid | resp1_valid, 1'b0);
            chk64("rst_result", result, 64'd0);
            chk1("rst_zero", zero, 1'b0);
        end
        reset = 1'b0;
        #1;
        chk1("post_rst_ready0", req0_ready, 1'b1);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        chk1("idle_busy", busy, 1'b0);

        // Directed: ADD, SUB to zero, unknown code, round-robin contention, backpressure.
        issue(1, 0, 64'h5, 64'h7, 4'b0010, 64'h0, 64'h0, 4'b0000, 0);
        issue(0, 1, 64'h0, 64'h0, 4'b0000, '1, '1, 4'b0110, 0);
        issue(0, 1, 64'h0, 64'h0, 4'b0000, 64'h1234, 64'h99, 4'b1111, 0);
        for (int i = 0; i < 3; i++)
            issue(1, 1, 64'h1, 64'h1, 4'b0010, 64'hF0, 64'h0F, 4'b0001, 0);
        issue(1, 1, 64'hDEAD_BEEF, 64'h1, 4'b0110, 64'h3, 64'h4, 4'b0010, 5);

        // Reset while in EXEC: operation dropped, priority back to requester 0.
        req0_valid = 1'b0; req1_valid = 1'b1;
        req1_a = 64'h11; req1_b = 64'h22; req1_ctrl = 4'b0010;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        #1;
        chk1("mid_accept1", req1_ready, 1'b1);
        @(posedge clk); #1;
        chk1("mid_exec_busy", busy, 1'b1);
        reset = 1'b1; req1_valid = 1'b0; req0_valid = 1'b1;
        #1;
        chk1("mid_rst_ready0", req0_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0; req0_valid = 1'b0;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk1("mid_no_resp", resp0_valid | resp1_valid, 1'b0);
            chk1("mid_idle_busy", busy, 1'b0);
        end
        turn = 0;
        issue(1, 1, 64'h8, 64'h8, 4'b0110, 64'h1, 64'h2, 4'b0001, 0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            logic v0, v1;
            logic [3:0] c0, c1;
            logic [63:0] a0, b0, a1, b1;
            int sel;
            sel = $urandom_range(0, 2);
            v0  = (sel != 1);
            v1  = (sel != 0);
            c0  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                               : 4'($urandom_range(0, 1) * 6 + $urandom_range(0, 1));
            c1  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0010;
            a0  = rnd64(); b0 = ($urandom_range(0, 3) == 0) ? a0 : rnd64();
            a1  = rnd64(); b1 = rnd64();
            issue(v0, v1, a0, b0, c0, a1, b1, c1, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
